// File: rtl/syn_fifo_param.sv
// Single-clock parameterised FIFO with registered read data, level flags and error flags.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky and add the err_clr port.
module syn_fifo_param #(
   parameter int WIDTH         = 8,
   parameter int FIFO_SIZE     = 16,
   parameter int AFULL_THRESH  = FIFO_SIZE - 2,
   parameter int AEMPTY_THRESH = 2,
   localparam int PTR_WIDTH    = $clog2(FIFO_SIZE)
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 rd_en,
   output logic [WIDTH-1:0]     rdata,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow,
   output logic                 underflow,
   output logic [PTR_WIDTH:0]   count
`ifdef FIFO_STICKY_ERR_EN
   ,
   input  logic                 err_clr
`endif
);

   localparam int CW = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] FULL_CNT   = CW'(FIFO_SIZE);
   localparam logic [PTR_WIDTH:0] AFULL_CNT  = CW'(AFULL_THRESH);
   localparam logic [PTR_WIDTH:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

   logic [WIDTH-1:0]     mem [FIFO_SIZE];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic                 rd_accept;
   logic                 wr_accept;
   logic                 ovf_evt;
   logic                 unf_evt;

   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_CNT);
   assign almost_empty = (count <= AEMPTY_CNT);

   // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
   always_comb begin
      rd_accept = 1'b0;
      wr_accept = 1'b0;
      ovf_evt   = 1'b0;
      unf_evt   = 1'b0;
      if (!flush) begin
         rd_accept = rd_en && !empty;
         wr_accept = wr_en && (!full || rd_accept);
         ovf_evt   = wr_en && full && !rd_accept;
         unf_evt   = rd_en && empty;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
            rdata  <= mem[rd_ptr];
         end
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_STICKY_ERR_EN
   // Setting takes priority over err_clr in the same cycle.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (unf_evt)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_evt;
         underflow <= unf_evt;
      end
   end
`endif

endmodule
